// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a FALL_THROUGH=0 FIFO into a valid/ready
// stream through a 2-entry skid buffer, so the pop never looks at ready_i.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             clears buffer and beat counter next edge
//   fifo_empty_i        FIFO empty flag
//   fifo_data_i         FIFO head word (valid while not empty)
//   fifo_pop_o          pop strobe to FIFO
//   valid_o, ready_i    output stream handshake
//   data_o              output word (head register)
//   last_o              final beat of a PKT_LEN-beat packet
//   beat_cnt_o          beat index within the packet
//
// Build option: define FIFO_STREAM_READER_LAST_EN to implement the
// beat counter and last_o framing; otherwise last_o and beat_cnt_o are 0.

module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 4,
  parameter int CNT_W      = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic [CNT_W-1:0]      beat_cnt_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL2 = 2'd2;

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;

  logic w_pop;
  logic w_hs;
  logic w_valid;

  assign w_valid = (r_state != ST_EMPTY);
  assign w_hs    = w_valid && ready_i;

  // Pop depends only on registered occupancy: the skid slot guarantees
  // room for the word popped this cycle even if ready_i stays low.
  assign w_pop = !fifo_empty_i && !flush_i && !rst_i
               && (r_state != ST_FULL2);

  assign fifo_pop_o = w_pop;
  assign valid_o    = w_valid;
  assign data_o     = r_head;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else if (flush_i) begin
      r_state <= ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_pop) begin
            r_head  <= fifo_data_i;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_pop && w_hs) begin
            r_head  <= fifo_data_i;
          end else if (w_pop) begin
            r_skid  <= fifo_data_i;
            r_state <= ST_FULL2;
          end else if (w_hs) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL2: begin
          if (w_hs) begin
            r_head  <= r_skid;
            r_state <= ST_ONE;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

`ifdef FIFO_STREAM_READER_LAST_EN

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

  logic [CNT_W-1:0] r_bc;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_bc <= '0;
    end else if (w_hs) begin
      if (r_bc == LAST_BEAT) begin
        r_bc <= '0;
      end else begin
        r_bc <= r_bc + 1'b1;
      end
    end
  end

  assign beat_cnt_o = r_bc;
  assign last_o     = w_valid && (r_bc == LAST_BEAT);

`else

  assign beat_cnt_o = '0;
  assign last_o     = 1'b0;

`endif

endmodule
